// File: rtl/hex_display_pkg.sv
// Shared types and constants for the seven-segment display driver.
package hex_display_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_BLANK     = 3'd0;
  localparam state_t ST_STEADY    = 3'd1;
  localparam state_t ST_BLINK_ON  = 3'd2;
  localparam state_t ST_BLINK_OFF = 3'd3;
  localparam state_t ST_TEST      = 3'd4;

  localparam int unsigned DIGIT_LSB = 0;
  localparam int unsigned DIGIT_MSB = 3;
  localparam int unsigned BLANK_BIT = 4;
  localparam int unsigned BLINK_BIT = 5;
  localparam int unsigned DP_BIT    = 6;
  localparam int unsigned TEST_BIT  = 7;

  localparam logic [6:0] SEG_OFF  = 7'h00;
  localparam logic [6:0] SEG_ALL  = 7'h7F;
  localparam logic [6:0] SEG_DASH = 7'h40;

  // Capture register comes out of reset requesting a blank display.
  localparam logic [7:0] CTRL_RESET = 8'h10;

endpackage

// File: rtl/hex_display_driver_if.sv
// Control byte in, segment drive and blink status out.
interface hex_display_driver_if;

  logic [7:0] ctrl_in;
  logic [6:0] seg;
  logic       dp;
  logic       blink_phase;

  modport master (
    output ctrl_in,
    input  seg,
    input  dp,
    input  blink_phase
  );

  modport slave (
    input  ctrl_in,
    output seg,
    output dp,
    output blink_phase
  );

endinterface

// File: rtl/seg7_decode.sv
// Combinational nibble to active-high seven-segment code (bit0=a .. bit6=g).
// Define HEX_DISPLAY_ALPHA_EN to show A..F; otherwise 10..15 show a dash.
module seg7_decode
  import hex_display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (digit)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
`ifdef HEX_DISPLAY_ALPHA_EN
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
`endif
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/hex_display_driver.sv
// Single-digit seven-segment driver with blank, blink, dp and lamp test.
// Alpha digits A..F are enabled by defining HEX_DISPLAY_ALPHA_EN (see seg7_decode).
module hex_display_driver
  import hex_display_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned BLINK_HZ   = 2,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hex_display_driver_if.slave  bus
);

  localparam int unsigned HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HALF - 1);

  localparam logic [6:0] SEG_UNLIT = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [6:0] SEG_LIT   = ACTIVE_LOW ? ~SEG_ALL : SEG_ALL;
  localparam logic       DP_UNLIT  = ACTIVE_LOW;

  // Stage 1: capture and change-detect history
  logic [7:0] cap_q;
  logic [3:0] prev_digit_q;
  logic       prev_blink_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_q        <= CTRL_RESET;
      prev_digit_q <= CTRL_RESET[DIGIT_MSB:DIGIT_LSB];
      prev_blink_q <= CTRL_RESET[BLINK_BIT];
    end else begin
      cap_q        <= bus.ctrl_in;
      prev_digit_q <= cap_q[DIGIT_MSB:DIGIT_LSB];
      prev_blink_q <= cap_q[BLINK_BIT];
    end
  end

  logic [3:0] digit;
  logic [6:0] digit_seg;

  assign digit = cap_q[DIGIT_MSB:DIGIT_LSB];

  seg7_decode u_decode (
    .digit (digit),
    .seg   (digit_seg)
  );

  // Stage 2: blink timer, FSM and output registers
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;
  state_t           state_q, state_d;
  logic [6:0]       seg_q, seg_hi;
  logic             dp_q, dp_hi;
  logic             restart, wrap;

  assign restart = (digit != prev_digit_q) || (cap_q[BLINK_BIT] && !prev_blink_q);
  assign wrap    = (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d   = cnt_q + 1'b1;
    phase_d = phase_q;
    // A restart shows a new digit immediately for a full visible half-period.
    if (restart) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (wrap) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end
  end

  always_comb begin
    state_d = ST_STEADY;
    if (cap_q[TEST_BIT]) begin
      state_d = ST_TEST;
    end else if (cap_q[BLANK_BIT]) begin
      state_d = ST_BLANK;
    end else if (cap_q[BLINK_BIT]) begin
      state_d = phase_d ? ST_BLINK_ON : ST_BLINK_OFF;
    end
  end

  always_comb begin
    seg_hi = SEG_OFF;
    dp_hi  = 1'b0;
    case (state_d)
      ST_TEST: begin
        seg_hi = SEG_ALL;
        dp_hi  = 1'b1;
      end
      ST_STEADY, ST_BLINK_ON: begin
        seg_hi = digit_seg;
        dp_hi  = cap_q[DP_BIT];
      end
      default: begin
        seg_hi = SEG_OFF;
        dp_hi  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
      state_q <= ST_BLANK;
      seg_q   <= SEG_UNLIT;
      dp_q    <= DP_UNLIT;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      state_q <= state_d;
      seg_q   <= ACTIVE_LOW ? ~seg_hi : seg_hi;
      dp_q    <= ACTIVE_LOW ? ~dp_hi : dp_hi;
    end
  end

  assign bus.seg         = seg_q;
  assign bus.dp          = dp_q;
  assign bus.blink_phase = phase_q;

  // Lamp test must always light every segment.
  a_test_all_lit : assert property (@(posedge clk) disable iff (!reset_n)
    (state_q == ST_TEST) |-> (seg_q == SEG_LIT));

endmodule

// File: doc/hex_display_driver.md
Name: hex_display_driver

Overview:
- Downstream consumer of the 8-bit control byte from the alarm system's seven-segment PIO output register.
- Turns that byte into the segment drive for one digit, with blank, blink, decimal-point and lamp-test control.
- Outputs feed the board HEX pins directly.
- All outputs are registered; the blink timing is generated locally from clk.

Parameters:
- CLK_HZ, 50000000, clk frequency in Hz.
- BLINK_HZ, 2, full blink period rate in Hz. HALF = CLK_HZ/(2*BLINK_HZ) clk cycles per phase; HALF must be >= 2.
- ACTIVE_LOW, 1, 1 = segment/dp outputs low-true (board default); 0 = high-true.

Ports:
- clk, in, 1, system clock.
- reset_n, in, 1, asynchronous active-low reset.
- ctrl_in, in, 8, control byte from the PIO: [3:0] digit, [4] blank, [5] blink, [6] dp, [7] lamp test.
- seg, out, 7, segment drive, bit0=a .. bit6=g, polarity set by ACTIVE_LOW.
- dp, out, 1, decimal point drive, same polarity as seg.
- blink_phase, out, 1, 1 = blink visible half-period; status for other digits to sync to.

Behaviour:
- Reset (async assert, sync release):
  - seg and dp = all unlit: 7'h7F/1 if ACTIVE_LOW, 7'h00/0 otherwise.
  - blink_phase = 1, blink counter = 0, capture register = 8'h10 (blank), FSM = BLANK.
- Stage 1: ctrl_in is registered every cycle into cap.
- Stage 2: FSM state and seg/dp are registered from cap.
- Latency: ctrl_in to seg/dp is exactly 2 clk cycles.
- Blink timer:
  - Counter runs 0..HALF-1 continuously in every state.
  - On wrap (count==HALF-1) it returns to 0 and toggles blink_phase.
  - Counter width = clog2(HALF).
- Change restart:
  - Triggers if cap[3:0] differs from the previous cycle's cap[3:0], or cap[5] rises.
  - Counter is cleared to 0 and blink_phase forced to 1 that cycle.
  - A new digit is therefore shown immediately for a full visible half-period.
  - Restart has priority over a wrap in the same cycle.
- FSM states: BLANK, STEADY, BLINK_ON, BLINK_OFF, TEST.
- Next state is evaluated every cycle by priority:
  - cap[7] -> TEST.
  - else cap[4] -> BLANK.
  - else cap[5] -> BLINK_ON if (next) blink_phase==1, BLINK_OFF otherwise.
  - else -> STEADY.
- Outputs per state (active-high before the polarity stage):
  - TEST: seg=7F, dp=1.
  - BLANK: seg=00, dp=0.
  - STEADY / BLINK_ON: seg=decode(cap[3:0]), dp=cap[6].
  - BLINK_OFF: seg=00, dp=0.
- dp blinks together with the digit.
- Decode, active-high hex: 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F.
  - Digits A..F are covered by the optional feature.
- Polarity stage: when ACTIVE_LOW=1, seg and dp are inverted. blink_phase is never inverted.
- Boundary cases:
  - Leaving blink mode: next cycle goes to STEADY regardless of phase; the timer keeps running.
  - TEST while blinking: the timer continues. On TEST release, the FSM resumes with the current phase; there is no restart unless the digit changed.
  - Reset mid-blink returns all state to reset values immediately.
- No handshake: ctrl_in is level-sampled and must be synchronous to clk (same clock domain as the PIO).

Optional Feature:
- Macro: HEX_DISPLAY_ALPHA_EN.
- Defined: digits 10..15 decode to A:77 b:7C C:39 d:5E E:79 F:71.
- Undefined: digits 10..15 show a dash, seg=40 (g only). dp is unaffected.

Decomposition:
- Shared package hex_display_pkg holds:
  - State enum type.
  - Field index constants (DIGIT_LSB/MSB, BLANK_BIT, BLINK_BIT, DP_BIT, TEST_BIT).
  - Segment code constants SEG_OFF, SEG_ALL, SEG_DASH.
- One natural sub-module, seg7_decode: purely combinational nibble-to-7-segment lookup, with the alpha macro applied inside it.
- Timer and FSM stay in the top level.

Test Plan:
- Bench parameters: CLK_HZ=20, BLINK_HZ=2, so HALF=5. ACTIVE_LOW=1 unless stated.
- Reset release with ctrl_in=8'h00: seg=7F, dp=1 during reset; then seg=7'h40 (~3F) exactly 2 cycles after the first sampling edge.
- ctrl_in=8'h25 (blink, digit 5): seg=~6D for 5 cycles, then 7F for 5 cycles, repeating; blink_phase toggles every 5 cycles.
- Mid-dark-phase change ctrl_in 8'h25 -> 8'h27: blink_phase returns to 1 and seg=~07 two cycles after the change, then holds for a full 5 cycles.
- ctrl_in=8'h9A (test overrides blank/digit): seg=00, dp=0 (all lit) after 2 cycles. Then 8'h1A: seg=7F, dp=1.
- ctrl_in=8'h4B: seg=~7C, dp=0 with HEX_DISPLAY_ALPHA_EN defined; seg=~40, dp=0 without it.
- ACTIVE_LOW=0, ctrl_in=8'h08: seg=7F, dp=0. Assert reset_n low mid-cycle: seg=00 and blink_phase=1 immediately, without waiting for a clk edge.
